// File: rtl/decode_mem_sched_if.sv
// Request/response bundle between decode, the memory operand scheduler and the
// operand mux. Handshakes on both sides are strict valid/ready: a transfer
// happens on a rising clock edge where valid and ready are both high; a
// producer holding valid keeps its payload stable until that edge, and ready
// never depends combinationally on valid.
interface decode_mem_sched_if;
    // request side
    logic        in_valid;
    logic        in_ready;
    logic        opnd0_mem_req;
    logic        opnd1_mem_req;
    logic [1:0]  opnd0_scale;
    logic [1:0]  opnd1_scale;
    logic [31:0] opnd0_index;
    logic [31:0] opnd0_base;
    logic [31:0] opnd0_disp;
    logic [31:0] opnd1_index;
    logic [31:0] opnd1_base;
    logic [31:0] opnd1_disp;
    logic        memop_is_phony;
    logic        hint1_is_write;
    logic        hint2_is_write;
    logic [31:0] hint1_address;
    logic [31:0] hint1_data;
    logic [31:0] hint2_address;
    logic [31:0] hint2_data;

    // response side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] opnd0_addr;
    logic [31:0] opnd1_addr;
    logic [31:0] opnd0_memval;
    logic [31:0] opnd1_memval;
    logic        opnd0_miss;
    logic        opnd1_miss;
    logic        hint1_used;
    logic        hint2_used;

    // decode / operand-mux side
    modport master (
        output in_valid, opnd0_mem_req, opnd1_mem_req,
        output opnd0_scale, opnd1_scale,
        output opnd0_index, opnd0_base, opnd0_disp,
        output opnd1_index, opnd1_base, opnd1_disp,
        output memop_is_phony, hint1_is_write, hint2_is_write,
        output hint1_address, hint1_data, hint2_address, hint2_data,
        output out_ready,
        input  in_ready, out_valid,
        input  opnd0_addr, opnd1_addr, opnd0_memval, opnd1_memval,
        input  opnd0_miss, opnd1_miss, hint1_used, hint2_used
    );

    // scheduler side
    modport slave (
        input  in_valid, opnd0_mem_req, opnd1_mem_req,
        input  opnd0_scale, opnd1_scale,
        input  opnd0_index, opnd0_base, opnd0_disp,
        input  opnd1_index, opnd1_base, opnd1_disp,
        input  memop_is_phony, hint1_is_write, hint2_is_write,
        input  hint1_address, hint1_data, hint2_address, hint2_data,
        input  out_ready,
        output in_ready, out_valid,
        output opnd0_addr, opnd1_addr, opnd0_memval, opnd1_memval,
        output opnd0_miss, opnd1_miss, hint1_used, hint2_used
    );
endinterface

// File: rtl/decode_mem_sched.sv
// Memory operand scheduler: one shared AGU computes operand#0 then operand#1
// effective addresses, matches each against the two read hints and returns the
// memory value. Holds one instruction at a time; all outputs are registered.
module decode_mem_sched (
    input  logic                     clk,
    input  logic                     rst_n,
    decode_mem_sched_if.slave        bus,
    output logic [1:0]               dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AGU0 = 2'd1;
    localparam logic [1:0] S_AGU1 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // FSM
    logic [1:0]  state_q, state_d;

    // captured request
    logic        mem0_q, mem0_d;
    logic        mem1_q, mem1_d;
    logic [1:0]  scale0_q, scale0_d;
    logic [1:0]  scale1_q, scale1_d;
    logic [31:0] index0_q, index0_d;
    logic [31:0] base0_q, base0_d;
    logic [31:0] disp0_q, disp0_d;
    logic [31:0] index1_q, index1_d;
    logic [31:0] base1_q, base1_d;
    logic [31:0] disp1_q, disp1_d;
    logic        phony_q, phony_d;
    logic        h1_wr_q, h1_wr_d;
    logic        h2_wr_q, h2_wr_d;
    logic [31:0] h1_addr_q, h1_addr_d;
    logic [31:0] h1_data_q, h1_data_d;
    logic [31:0] h2_addr_q, h2_addr_d;
    logic [31:0] h2_data_q, h2_data_d;

    // results
    logic        out_valid_q, out_valid_d;
    logic [31:0] addr0_q, addr0_d;
    logic [31:0] addr1_q, addr1_d;
    logic [31:0] memval0_q, memval0_d;
    logic [31:0] memval1_q, memval1_d;
    logic        miss0_q, miss0_d;
    logic        miss1_q, miss1_d;
    logic        used1_q, used1_d;
    logic        used2_q, used2_d;

    // shared AGU and hint lookup
    logic        agu_sel1;
    logic [1:0]  agu_scale;
    logic [31:0] agu_index;
    logic [31:0] agu_base;
    logic [31:0] agu_disp;
    logic [31:0] agu_addr;
    logic        h1_hit;
    logic        h2_hit;
    logic [31:0] res_memval;
    logic        res_miss;
    logic        res_u1;
    logic        res_u2;
    logic        accept;

    // Single AGU muxed by state; the hint lookup result is shared by both AGU states.
    always_comb begin
        agu_sel1   = (state_q == S_AGU1);
        agu_scale  = agu_sel1 ? scale1_q : scale0_q;
        agu_index  = agu_sel1 ? index1_q : index0_q;
        agu_base   = agu_sel1 ? base1_q  : base0_q;
        agu_disp   = agu_sel1 ? disp1_q  : disp0_q;
        agu_addr   = agu_base + (agu_index << agu_scale) + agu_disp;

        // write hints never satisfy a read; the first hint wins when both match
        h1_hit     = !h1_wr_q && (h1_addr_q == agu_addr);
        h2_hit     = !h2_wr_q && (h2_addr_q == agu_addr);

        res_memval = 32'd0;
        res_miss   = 1'b0;
        res_u1     = 1'b0;
        res_u2     = 1'b0;
        if (phony_q) begin
            res_memval = agu_addr;
        end else if (h1_hit) begin
            res_memval = h1_data_q;
            res_u1     = 1'b1;
        end else if (h2_hit) begin
            res_memval = h2_data_q;
            res_u2     = 1'b1;
        end else begin
            res_miss   = 1'b1;
        end
    end

    // Next-state: capture on accept, fill one operand per AGU state, hold in DONE.
    always_comb begin
        state_d     = state_q;
        mem0_d      = mem0_q;
        mem1_d      = mem1_q;
        scale0_d    = scale0_q;
        scale1_d    = scale1_q;
        index0_d    = index0_q;
        base0_d     = base0_q;
        disp0_d     = disp0_q;
        index1_d    = index1_q;
        base1_d     = base1_q;
        disp1_d     = disp1_q;
        phony_d     = phony_q;
        h1_wr_d     = h1_wr_q;
        h2_wr_d     = h2_wr_q;
        h1_addr_d   = h1_addr_q;
        h1_data_d   = h1_data_q;
        h2_addr_d   = h2_addr_q;
        h2_data_d   = h2_data_q;
        out_valid_d = out_valid_q;
        addr0_d     = addr0_q;
        addr1_d     = addr1_q;
        memval0_d   = memval0_q;
        memval1_d   = memval1_q;
        miss0_d     = miss0_q;
        miss1_d     = miss1_q;
        used1_d     = used1_q;
        used2_d     = used2_q;

        accept = bus.in_valid && (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mem0_d    = bus.opnd0_mem_req;
                    mem1_d    = bus.opnd1_mem_req;
                    scale0_d  = bus.opnd0_scale;
                    scale1_d  = bus.opnd1_scale;
                    index0_d  = bus.opnd0_index;
                    base0_d   = bus.opnd0_base;
                    disp0_d   = bus.opnd0_disp;
                    index1_d  = bus.opnd1_index;
                    base1_d   = bus.opnd1_base;
                    disp1_d   = bus.opnd1_disp;
                    phony_d   = bus.memop_is_phony;
                    h1_wr_d   = bus.hint1_is_write;
                    h2_wr_d   = bus.hint2_is_write;
                    h1_addr_d = bus.hint1_address;
                    h1_data_d = bus.hint1_data;
                    h2_addr_d = bus.hint2_address;
                    h2_data_d = bus.hint2_data;
                    // wipe previous results so nothing stale survives
                    addr0_d   = 32'd0;
                    addr1_d   = 32'd0;
                    memval0_d = 32'd0;
                    memval1_d = 32'd0;
                    miss0_d   = 1'b0;
                    miss1_d   = 1'b0;
                    used1_d   = 1'b0;
                    used2_d   = 1'b0;
                    if (bus.opnd0_mem_req) begin
                        state_d = S_AGU0;
                    end else if (bus.opnd1_mem_req) begin
                        state_d = S_AGU1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_AGU0: begin
                addr0_d   = agu_addr;
                memval0_d = res_memval;
                miss0_d   = res_miss;
                used1_d   = used1_q | res_u1;
                used2_d   = used2_q | res_u2;
                state_d   = mem1_q ? S_AGU1 : S_DONE;
            end
            S_AGU1: begin
                addr1_d   = agu_addr;
                memval1_d = res_memval;
                miss1_d   = res_miss;
                used1_d   = used1_q | res_u1;
                used2_d   = used2_q | res_u2;
                state_d   = S_DONE;
            end
            S_DONE: begin
                // out_valid rises one cycle after entering DONE; leave only on handshake
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and data registers; reset drops any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mem0_q      <= 1'b0;
            mem1_q      <= 1'b0;
            scale0_q    <= 2'd0;
            scale1_q    <= 2'd0;
            index0_q    <= 32'd0;
            base0_q     <= 32'd0;
            disp0_q     <= 32'd0;
            index1_q    <= 32'd0;
            base1_q     <= 32'd0;
            disp1_q     <= 32'd0;
            phony_q     <= 1'b0;
            h1_wr_q     <= 1'b0;
            h2_wr_q     <= 1'b0;
            h1_addr_q   <= 32'd0;
            h1_data_q   <= 32'd0;
            h2_addr_q   <= 32'd0;
            h2_data_q   <= 32'd0;
            out_valid_q <= 1'b0;
            addr0_q     <= 32'd0;
            addr1_q     <= 32'd0;
            memval0_q   <= 32'd0;
            memval1_q   <= 32'd0;
            miss0_q     <= 1'b0;
            miss1_q     <= 1'b0;
            used1_q     <= 1'b0;
            used2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem0_q      <= mem0_d;
            mem1_q      <= mem1_d;
            scale0_q    <= scale0_d;
            scale1_q    <= scale1_d;
            index0_q    <= index0_d;
            base0_q     <= base0_d;
            disp0_q     <= disp0_d;
            index1_q    <= index1_d;
            base1_q     <= base1_d;
            disp1_q     <= disp1_d;
            phony_q     <= phony_d;
            h1_wr_q     <= h1_wr_d;
            h2_wr_q     <= h2_wr_d;
            h1_addr_q   <= h1_addr_d;
            h1_data_q   <= h1_data_d;
            h2_addr_q   <= h2_addr_d;
            h2_data_q   <= h2_data_d;
            out_valid_q <= out_valid_d;
            addr0_q     <= addr0_d;
            addr1_q     <= addr1_d;
            memval0_q   <= memval0_d;
            memval1_q   <= memval1_d;
            miss0_q     <= miss0_d;
            miss1_q     <= miss1_d;
            used1_q     <= used1_d;
            used2_q     <= used2_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.out_valid    = out_valid_q;
    assign bus.opnd0_addr   = addr0_q;
    assign bus.opnd1_addr   = addr1_q;
    assign bus.opnd0_memval = memval0_q;
    assign bus.opnd1_memval = memval1_q;
    assign bus.opnd0_miss   = miss0_q;
    assign bus.opnd1_miss   = miss1_q;
    assign bus.hint1_used   = used1_q;
    assign bus.hint2_used   = used2_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_decode_mem_sched.sv
// Bench for decode_mem_sched: drives requests through the interface, pushes
// the expected result of each onto a queue, and pops/compares when out_valid.
module tb_decode_mem_sched;

  typedef struct packed {
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] m0;
    logic [31:0] m1;
    logic        x0;
    logic        x1;
    logic        u1;
    logic        u2;
    logic [3:0]  lat;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_mem_sched_if bus();
  logic [1:0] dbg_state;

  decode_mem_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // reference for one operand
  function automatic void model_opnd(
    input  logic        req,
    input  logic        ph,
    input  logic [1:0]  sc,
    input  logic [31:0] idx,
    input  logic [31:0] base,
    input  logic [31:0] disp,
    input  logic        h1w,
    input  logic [31:0] h1a,
    input  logic [31:0] h1d,
    input  logic        h2w,
    input  logic [31:0] h2a,
    input  logic [31:0] h2d,
    output logic [31:0] a,
    output logic [31:0] m,
    output logic        x,
    output logic        u1,
    output logic        u2
  );
    logic [31:0] ea;
    ea = base + (idx << sc) + disp;
    a = 32'd0; m = 32'd0; x = 1'b0; u1 = 1'b0; u2 = 1'b0;
    if (req) begin
      a = ea;
      if (ph) m = ea;
      else if (!h1w && h1a == ea) begin m = h1d; u1 = 1'b1; end
      else if (!h2w && h2a == ea) begin m = h2d; u2 = 1'b1; end
      else x = 1'b1;
    end
  endfunction

  task automatic scramble_inputs();
    bus.opnd0_mem_req  = 1'($urandom_range(0, 1));
    bus.opnd1_mem_req  = 1'($urandom_range(0, 1));
    bus.opnd0_scale    = 2'($urandom_range(0, 3));
    bus.opnd1_scale    = 2'($urandom_range(0, 3));
    bus.opnd0_index    = $urandom;
    bus.opnd0_base     = $urandom;
    bus.opnd0_disp     = $urandom;
    bus.opnd1_index    = $urandom;
    bus.opnd1_base     = $urandom;
    bus.opnd1_disp     = $urandom;
    bus.memop_is_phony = 1'($urandom_range(0, 1));
    bus.hint1_is_write = 1'($urandom_range(0, 1));
    bus.hint2_is_write = 1'($urandom_range(0, 1));
    bus.hint1_address  = $urandom;
    bus.hint1_data     = $urandom;
    bus.hint2_address  = $urandom;
    bus.hint2_data     = $urandom;
  endtask

  // driver: present a request, push its expectation, wait for the accept edge
  task automatic issue(
    input logic        push,
    input logic        m0,
    input logic        m1,
    input logic [1:0]  s0,
    input logic [31:0] i0,
    input logic [31:0] b0,
    input logic [31:0] d0,
    input logic [1:0]  s1,
    input logic [31:0] i1,
    input logic [31:0] b1,
    input logic [31:0] d1,
    input logic        ph,
    input logic        h1w,
    input logic [31:0] h1a,
    input logic [31:0] h1d,
    input logic        h2w,
    input logic [31:0] h2a,
    input logic [31:0] h2d
  );
    exp_t e;
    int n;
    bus.opnd0_mem_req = m0;  bus.opnd1_mem_req = m1;
    bus.opnd0_scale = s0;    bus.opnd0_index = i0; bus.opnd0_base = b0; bus.opnd0_disp = d0;
    bus.opnd1_scale = s1;    bus.opnd1_index = i1; bus.opnd1_base = b1; bus.opnd1_disp = d1;
    bus.memop_is_phony = ph;
    bus.hint1_is_write = h1w; bus.hint1_address = h1a; bus.hint1_data = h1d;
    bus.hint2_is_write = h2w; bus.hint2_address = h2a; bus.hint2_data = h2d;
    model_opnd(m0, ph, s0, i0, b0, d0, h1w, h1a, h1d, h2w, h2a, h2d, e.a0, e.m0, e.x0, e.u1, e.u2);
    begin
      logic u1b, u2b;
      model_opnd(m1, ph, s1, i1, b1, d1, h1w, h1a, h1d, h2w, h2a, h2d, e.a1, e.m1, e.x1, u1b, u2b);
      e.u1 = e.u1 | u1b;
      e.u2 = e.u2 | u2b;
    end
    e.lat = 4'd1 + 4'(m0) + 4'(m1);
    if (push) exp_q.push_back(e);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_val({tag, ".addr0"},  bus.opnd0_addr,   e.a0);
    check_val({tag, ".addr1"},  bus.opnd1_addr,   e.a1);
    check_val({tag, ".mval0"},  bus.opnd0_memval, e.m0);
    check_val({tag, ".mval1"},  bus.opnd1_memval, e.m1);
    check_val({tag, ".miss0"},  32'(bus.opnd0_miss), 32'(e.x0));
    check_val({tag, ".miss1"},  32'(bus.opnd1_miss), 32'(e.x1));
    check_val({tag, ".used1"},  32'(bus.hint1_used), 32'(e.u1));
    check_val({tag, ".used2"},  32'(bus.hint2_used), 32'(e.u2));
  endtask

  // scoreboard side: wait for out_valid, pop, compare, optional backpressure
  task automatic collect(input string tag, input int bp);
    exp_t e;
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!bus.out_valid && k < 20);
    check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check_val({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, ".latency"}, 32'(k), 32'(e.lat));
      check_outputs(tag, e);
      for (int c = 0; c < bp; c++) begin
        @(posedge clk); #1;
        check_val({tag, ".bp_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, ".bp_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_outputs({tag, ".bp"}, e);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check_val("rst.in_ready",  32'(bus.in_ready),  32'd1);
    check_val("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst.addr0",     bus.opnd0_addr,     32'd0);
    check_val("rst.mval1",     bus.opnd1_memval,   32'd0);
    check_val("rst.state",     32'(dbg_state),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // both operands via hints
    issue(1, 1, 1, 2'd2, 32'd4, 32'h1000, 32'hFFFF_FFF0, 2'd0, 32'd0, 32'h2000, 32'd8,
          0, 0, 32'h1000, 32'hDEAD_BEEF, 0, 32'h2008, 32'h1234_5678);
    collect("both", 0);
    check_val("both.const_addr0", bus.opnd0_addr,   32'h1000);
    check_val("both.const_addr1", bus.opnd1_addr,   32'h2008);
    check_val("both.const_mval0", bus.opnd0_memval, 32'hDEAD_BEEF);
    check_val("both.const_mval1", bus.opnd1_memval, 32'h1234_5678);

    // wrap and hint priority
    issue(1, 1, 0, 2'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 2'd0, 32'd0, 32'd0, 32'd0,
          0, 0, 32'h4, 32'hA, 0, 32'h4, 32'hB);
    collect("wrap", 0);
    check_val("wrap.const_mval0", bus.opnd0_memval, 32'hA);
    check_val("wrap.const_used2", 32'(bus.hint2_used), 32'd0);

    // write hint ignored -> miss
    issue(1, 1, 0, 2'd0, 32'd0, 32'h4, 32'd0, 2'd0, 32'd0, 32'd0, 32'd0,
          0, 1, 32'h4, 32'h55, 0, 32'h8, 32'h66);
    collect("whint", 0);
    check_val("whint.const_miss0", 32'(bus.opnd0_miss), 32'd1);

    // phony (LEA-style) on operand#1 only
    issue(1, 0, 1, 2'd0, 32'd0, 32'd0, 32'd0, 2'd3, 32'd3, 32'h100, 32'd0,
          1, 0, 32'h118, 32'h77, 0, 32'h118, 32'h88);
    collect("phony", 0);
    check_val("phony.const_mval1", bus.opnd1_memval, 32'h118);

    // no memory operand, 5 cycles of backpressure
    issue(1, 0, 0, 2'd0, 32'd1, 32'd2, 32'd3, 2'd0, 32'd4, 32'd5, 32'd6,
          0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0);
    collect("nomem", 5);

    // reset while operand#1 is in the AGU
    issue(0, 1, 1, 2'd1, 32'd2, 32'h300, 32'd0, 2'd0, 32'd0, 32'h400, 32'd4,
          0, 0, 32'h304, 32'h11, 0, 32'h404, 32'h22);
    @(posedge clk); #1;
    check_val("rst_mid.state_agu1", 32'(dbg_state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_mid.addr0",     bus.opnd0_addr,     32'd0);
    check_val("rst_mid.mval0",     bus.opnd0_memval,   32'd0);
    check_val("rst_mid.used1",     32'(bus.hint1_used), 32'd0);
    check_val("rst_mid.in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid.no_valid", 32'(bus.out_valid), 32'd0);
    issue(1, 0, 1, 2'd1, 32'd0, 32'd0, 32'd0, 2'd1, 32'd8, 32'h500, 32'd0,
          0, 0, 32'h510, 32'h99, 0, 32'h0, 32'h0);
    collect("post_rst", 0);

    // randomized requests, hints aimed at one of the operands half the time
    for (int t = 0; t < 8; t++) begin
      logic        m0, m1, ph;
      logic [1:0]  s0, s1;
      logic [31:0] i0, b0, d0, i1, b1, d1, h1a, h2a;
      logic        h1w, h2w;
      m0 = 1'($urandom_range(0, 1));
      m1 = 1'($urandom_range(0, 1));
      ph = ($urandom_range(0, 3) == 0);
      s0 = 2'($urandom_range(0, 3)); s1 = 2'($urandom_range(0, 3));
      i0 = $urandom; b0 = $urandom; d0 = $urandom;
      i1 = $urandom; b1 = $urandom; d1 = $urandom;
      h1w = ($urandom_range(0, 3) == 0);
      h2w = ($urandom_range(0, 3) == 0);
      h1a = $urandom_range(0, 1) ? (b0 + (i0 << s0) + d0) : $urandom;
      h2a = $urandom_range(0, 1) ? (b1 + (i1 << s1) + d1) : $urandom;
      issue(1, m0, m1, s0, i0, b0, d0, s1, i1, b1, d1, ph, h1w, h1a, $urandom, h2w, h2a, $urandom);
      collect("rand", $urandom_range(0, 2));
    end

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
